// File: rtl/pipeline_fetch_stage_pkg.sv
// rtl/pipeline_fetch_stage_pkg.sv - shared SiMPLE pipeline constants for fetch and control
// Next-PC select codes, branch_status state encoding and the NOP word.
package pipeline_fetch_stage_pkg;

  localparam logic [1:0] CTL_PC_PC4     = 2'd0;
  localparam logic [1:0] CTL_PC_PC_IMM  = 2'd1;
  localparam logic [1:0] CTL_PC_RS1_IMM = 2'd2;
  localparam logic [1:0] CTL_PC_PC4_BR  = 2'd3;

  typedef enum logic [1:0] {
    BR_IDLE    = 2'b00,
    BR_RESOLVE = 2'b01,
    BR_DRAIN   = 2'b10,
    BR_UNUSED  = 2'b11
  } branch_status_e;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - next-PC select with alignment handling
// FETCH_MISALIGN_TRAP_EN: flag misaligned targets instead of clearing bits [1:0].
module pc_next_mux
  import pipeline_fetch_stage_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] pc_imm_target_i,
  input  logic [31:0] rs1_imm_target_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);

  logic [31:0] raw_target;

  always_comb begin
    raw_target = pc_i + 32'd4;
    case (sel_i)
      CTL_PC_PC_IMM:  raw_target = pc_imm_target_i;
      CTL_PC_RS1_IMM: raw_target = rs1_imm_target_i;
      default:        raw_target = pc_i + 32'd4;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign next_pc_o    = raw_target;
  assign misaligned_o = |raw_target[1:0];
`else
  assign next_pc_o    = raw_target & ~32'd3;
  assign misaligned_o = 1'b0;
`endif

endmodule

// File: rtl/pipeline_fetch_stage.sv
// rtl/pipeline_fetch_stage.sv - SiMPLE fetch stage: PC, IF/ID register, jump sequencing FSM
// FETCH_MISALIGN_TRAP_EN selects sticky misaligned-target trapping over silent alignment.
module pipeline_fetch_stage
  import pipeline_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pc_write_enable,
  input  logic        no_stall,
  input  logic        jump_start,
  input  logic [1:0]  next_pc_select,
  input  logic [31:0] pc_imm_target,
  input  logic [31:0] rs1_imm_target,
  output logic [31:0] inst_mem_address,
  input  logic [31:0] inst_mem_read_data,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic [1:0]  branch_status,
  output logic        fetch_misaligned
);

  logic [31:0]    pc_q, pc_d;
  if_id_t         if_id_q, if_id_d;
  branch_status_e state_q, state_d;
  logic           misaligned_q, misaligned_d;
  logic [31:0]    next_pc;
  logic           target_misaligned;

  pc_next_mux u_pc_next_mux (
    .pc_i             (pc_q),
    .sel_i            (next_pc_select),
    .pc_imm_target_i  (pc_imm_target),
    .rs1_imm_target_i (rs1_imm_target),
    .next_pc_o        (next_pc),
    .misaligned_o     (target_misaligned)
  );

  // Once trapped, every PC write is dropped, including the offending one.
  always_comb begin
    pc_d         = pc_q;
    misaligned_d = misaligned_q;
    if (pc_write_enable) begin
      if (target_misaligned)
        misaligned_d = 1'b1;
      else if (!misaligned_q)
        pc_d = next_pc;
    end
  end

  always_comb begin
    if_id_d = if_id_q;
    if (no_stall) begin
      if (misaligned_q) begin
        if_id_d.inst  = INST_NOP;
        if_id_d.valid = 1'b0;
      end else begin
        if_id_d.inst  = inst_mem_read_data;
        if_id_d.valid = 1'b1;
      end
      if_id_d.pc = pc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      if_id_q.inst  <= INST_NOP;
      if_id_q.pc    <= RESET_PC;
      if_id_q.valid <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      if_id_q      <= if_id_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      state_q <= BR_IDLE;
    else
      state_q <= state_d;
  end

  // RESOLVE retries the target write until the PC is allowed to move.
  always_comb begin
    state_d = state_q;
    case (state_q)
      BR_IDLE:    if (jump_start) state_d = BR_RESOLVE;
      BR_RESOLVE: if (pc_write_enable) state_d = BR_DRAIN;
      BR_DRAIN:   if (no_stall) state_d = BR_IDLE;
      default:    state_d = BR_IDLE;
    endcase
  end

  always_comb begin
    branch_status    = state_q;
    inst_mem_address = pc_q;
    if_id_inst       = if_id_q.inst;
    if_id_pc         = if_id_q.pc;
    if_id_valid      = if_id_q.valid;
    fetch_misaligned = misaligned_q;
  end

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// tb/tb_pipeline_fetch_stage.sv - scoreboard bench for pipeline_fetch_stage
// Directed steps push expected post-edge state; a negedge monitor pops and compares.
module tb_pipeline_fetch_stage;

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_write_enable;
  logic        no_stall;
  logic        jump_start;
  logic [1:0]  next_pc_select;
  logic [31:0] pc_imm_target;
  logic [31:0] rs1_imm_target;
  logic [31:0] inst_mem_address;
  logic [31:0] inst_mem_read_data;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic [1:0]  branch_status;
  logic        fetch_misaligned;

  typedef struct {
    int          id;
    logic [31:0] pc;
    logic [31:0] ifpc;
    logic [31:0] inst;
    logic        v;
    logic [1:0]  bs;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   step_id = 0;

  always #5 clock = ~clock;

  // Address-tagged instruction memory
  assign inst_mem_read_data = inst_mem_address + 32'h1000_0000;

  pipeline_fetch_stage dut (
    .clock              (clock),
    .reset              (reset),
    .pc_write_enable    (pc_write_enable),
    .no_stall           (no_stall),
    .jump_start         (jump_start),
    .next_pc_select     (next_pc_select),
    .pc_imm_target      (pc_imm_target),
    .rs1_imm_target     (rs1_imm_target),
    .inst_mem_address   (inst_mem_address),
    .inst_mem_read_data (inst_mem_read_data),
    .if_id_inst         (if_id_inst),
    .if_id_pc           (if_id_pc),
    .if_id_valid        (if_id_valid),
    .branch_status      (branch_status),
    .fetch_misaligned   (fetch_misaligned)
  );

  task automatic chk(input int id, input string f, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL step%0d %s: got %h expected %h", id, f, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.id, "pc",            inst_mem_address,          mon_e.pc);
      chk(mon_e.id, "if_id_pc",      if_id_pc,                  mon_e.ifpc);
      chk(mon_e.id, "if_id_inst",    if_id_inst,                mon_e.inst);
      chk(mon_e.id, "if_id_valid",   {31'd0, if_id_valid},      {31'd0, mon_e.v});
      chk(mon_e.id, "branch_status", {30'd0, branch_status},    {30'd0, mon_e.bs});
      chk(mon_e.id, "misaligned",    {31'd0, fetch_misaligned}, {31'd0, mon_e.mis});
    end
  end

  task automatic step(input logic rst, input logic we, input logic ns, input logic js,
                      input logic [1:0] sel, input logic [31:0] pimm, input logic [31:0] rimm,
                      input logic [31:0] epc, input logic [31:0] eifpc, input logic [31:0] einst,
                      input logic ev, input logic [1:0] ebs, input logic emis);
    exp_t e;
    reset           = rst;
    pc_write_enable = we;
    no_stall        = ns;
    jump_start      = js;
    next_pc_select  = sel;
    pc_imm_target   = pimm;
    rs1_imm_target  = rimm;
    e.id = step_id; e.pc = epc; e.ifpc = eifpc; e.inst = einst;
    e.v = ev; e.bs = ebs; e.mis = emis;
    exp_q.push_back(e);
    step_id++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2;
    // reset beats every other input
    step(1, 1, 1, 1, 2'd1, 32'h0000_0100, 32'h0, 32'h0040_0000, 32'h0040_0000, 32'h0000_0013, 0, 2'b00, 0);
    // sequential fetch
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0040_0004, 32'h0040_0000, 32'h1040_0000, 1, 2'b00, 0);
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0040_0008, 32'h0040_0004, 32'h1040_0004, 1, 2'b00, 0);
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0040_000C, 32'h0040_0008, 32'h1040_0008, 1, 2'b00, 0);
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0040_0010, 32'h0040_000C, 32'h1040_000C, 1, 2'b00, 0);
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0040_0014, 32'h0040_0010, 32'h1040_0010, 1, 2'b00, 0);
    // JAL at 0x0040_0010 -> 0x0040_0100
    step(0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 32'h0040_0014, 32'h0040_0010, 32'h1040_0010, 1, 2'b01, 0);
    step(0, 1, 0, 0, 2'd1, 32'h0040_0100, 32'h0, 32'h0040_0100, 32'h0040_0010, 32'h1040_0010, 1, 2'b10, 0);
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0040_0104, 32'h0040_0100, 32'h1040_0100, 1, 2'b00, 0);
    // JALR with two stalled RESOLVE cycles, then a stalled DRAIN cycle
    step(0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 32'h0040_0104, 32'h0040_0100, 32'h1040_0100, 1, 2'b01, 0);
    step(0, 0, 0, 1, 2'd2, 32'h0, 32'h0040_0200, 32'h0040_0104, 32'h0040_0100, 32'h1040_0100, 1, 2'b01, 0);
    step(0, 0, 0, 0, 2'd2, 32'h0, 32'h0040_0200, 32'h0040_0104, 32'h0040_0100, 32'h1040_0100, 1, 2'b01, 0);
    step(0, 1, 0, 0, 2'd2, 32'h0, 32'h0040_0200, 32'h0040_0200, 32'h0040_0100, 32'h1040_0100, 1, 2'b10, 0);
    step(0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 32'h0040_0200, 32'h0040_0100, 32'h1040_0100, 1, 2'b10, 0);
    step(0, 1, 1, 1, 2'd0, 32'h0, 32'h0, 32'h0040_0204, 32'h0040_0200, 32'h1040_0200, 1, 2'b00, 0);
    // jump to 0xFFFF_FFFC, then PC+4 wraps
    step(0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 32'h0040_0204, 32'h0040_0200, 32'h1040_0200, 1, 2'b01, 0);
    step(0, 1, 0, 0, 2'd1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC, 32'h0040_0200, 32'h1040_0200, 1, 2'b10, 0);
    step(0, 1, 1, 0, 2'd3, 32'h0, 32'h0, 32'h0000_0000, 32'hFFFF_FFFC, 32'h0FFF_FFFC, 1, 2'b00, 0);
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0000_0004, 32'h0000_0000, 32'h1000_0000, 1, 2'b00, 0);
    // misaligned target 0x0040_0102
    step(0, 0, 0, 1, 2'd0, 32'h0, 32'h0, 32'h0000_0004, 32'h0000_0000, 32'h1000_0000, 1, 2'b01, 0);
    step(0, 1, 0, 0, 2'd1, 32'h0040_0102, 32'h0, TRAP ? 32'h0000_0004 : 32'h0040_0100,
         32'h0000_0000, 32'h1000_0000, 1, 2'b10, TRAP);
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, TRAP ? 32'h0000_0004 : 32'h0040_0104,
         TRAP ? 32'h0000_0004 : 32'h0040_0100, TRAP ? 32'h0000_0013 : 32'h1040_0100, !TRAP, 2'b00, TRAP);
    // reset while in DRAIN
    step(0, 0, 0, 1, 2'd0, 32'h0, 32'h0, TRAP ? 32'h0000_0004 : 32'h0040_0104,
         TRAP ? 32'h0000_0004 : 32'h0040_0100, TRAP ? 32'h0000_0013 : 32'h1040_0100, !TRAP, 2'b01, TRAP);
    step(0, 1, 0, 0, 2'd1, 32'h0040_0300, 32'h0, TRAP ? 32'h0000_0004 : 32'h0040_0300,
         TRAP ? 32'h0000_0004 : 32'h0040_0100, TRAP ? 32'h0000_0013 : 32'h1040_0100, !TRAP, 2'b10, TRAP);
    step(1, 1, 1, 1, 2'd0, 32'h0, 32'h0, 32'h0040_0000, 32'h0040_0000, 32'h0000_0013, 0, 2'b00, 0);
    step(0, 1, 1, 0, 2'd0, 32'h0, 32'h0, 32'h0040_0004, 32'h0040_0000, 32'h1040_0000, 1, 2'b00, 0);

    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
